// File: rtl/c2_pkg.sv
// Shared types and constants for the bit-serial two's-complement decode path.
package c2_pkg;

   localparam int C2_WIDTH = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } c2_dec_state_t;

   // Wide enough to count 0..width-1 without wrapping.
   function automatic int c2_cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/c2_serial_decoder_if.sv
// Start/busy/done conversion bus between a requester (master) and the decoder (slave).
interface c2_serial_decoder_if
   import c2_pkg::*;
#(
   parameter int WIDTH = C2_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] x;
   logic             busy;
   logic             done;
   logic             sign;
   logic [WIDTH-1:0] mag;

   modport master (output start, x, input busy, done, sign, mag);
   modport slave  (input start, x, output busy, done, sign, mag);
endinterface

// File: rtl/c2_serial_cell.sv
// One-bit copy-until-first-one-then-invert cell; seen_one updates on en, cleared by clr.
module c2_serial_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic b,
   input  logic neg,
   output logic out,
   output logic seen_one
);

   logic r_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen <= 1'b0;
      end else if (clr) begin
         r_seen <= 1'b0;
      end else if (en) begin
         r_seen <= r_seen | b;
      end
   end

   assign out      = b ^ (neg & r_seen);
   assign seen_one = r_seen;

endmodule

// File: rtl/c2_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude, LSB first; result and done WIDTH edges after accept.
// start is ignored while busy; a start during the DONE cycle is taken with no idle bubble.
module c2_serial_decoder
   import c2_pkg::*;
#(
   parameter int WIDTH = C2_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   c2_serial_decoder_if.slave   bus
);

   localparam int CW = c2_cnt_w(WIDTH);

   c2_dec_state_t    r_state;
   c2_dec_state_t    w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_work;
   logic [CW-1:0]    r_cnt;
   logic             r_neg;
   logic             r_busy;
   logic             r_done;
   logic             r_sign;
   logic [WIDTH-1:0] r_mag;

   logic             w_load;
   logic             w_run;
   logic             w_last;
   logic             w_out;
   logic             w_unused_seen;
   logic [WIDTH-1:0] w_work_nxt;

   assign w_load     = ((r_state == IDLE) || (r_state == DONE)) && bus.start;
   assign w_run      = (r_state == RUN);
   assign w_last     = w_run && (r_cnt == CW'(WIDTH - 1));
   assign w_work_nxt = {w_out, r_work[WIDTH-1:1]};

   c2_serial_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (w_load),
      .en       (w_run),
      .b        (r_shift[0]),
      .neg      (r_neg),
      .out      (w_out),
      .seen_one (w_unused_seen)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = bus.start ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_work  <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sign  <= 1'b0;
         r_mag   <= '0;
      end else begin
         r_busy <= (w_state_nxt == RUN);
         r_done <= (w_state_nxt == DONE);
         if (w_load) begin
            r_shift <= bus.x;
            r_neg   <= bus.x[WIDTH-1];
            r_cnt   <= '0;
            r_work  <= '0;
         end else if (w_run) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            r_work  <= w_work_nxt;
            r_cnt   <= r_cnt + CW'(1);
         end
         // Only the final bit's edge publishes, so mag/sign never show partial work.
         if (w_last) begin
            r_mag  <= w_work_nxt;
            r_sign <= r_neg;
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.sign = r_sign;
   assign bus.mag  = r_mag;

endmodule

// File: tb/tb_c2_serial_decoder.sv
// Scoreboard bench for c2_serial_decoder: expected sign/mag queued at launch, popped on done.
module tb_c2_serial_decoder;

   localparam int W = 7;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   c2_serial_decoder_if #(.WIDTH(W)) bus ();

   c2_serial_decoder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         n_chk      = 0;
   int         n_err      = 0;
   int         n_done     = 0;
   int         n_exp_done = 0;
   logic [W:0] sb_q[$];
   logic [W:0] mon_exp;
   logic [W-1:0] vecs[5] = '{7'b1110100, 7'b0001100, 7'b0000000, 7'b1000000, 7'b1111111};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x);
      logic         s;
      logic [W-1:0] m;
      s = x[W-1];
      m = s ? (~x + 1'b1) : x;
      return {s, m};
   endfunction

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check("sign", {31'd0, bus.sign}, {31'd0, mon_exp[W]});
            check("mag", {25'd0, bus.mag}, {25'd0, mon_exp[W-1:0]});
         end
      end
   end

   // Called at a negedge; the following posedge is the accepting edge k.
   task automatic launch(input logic [W-1:0] x);
      bus.start = 1'b1;
      bus.x     = x;
      sb_q.push_back(model(x));
      n_exp_done++;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic wait_done(input int elapsed);
      int lat;
      lat = 0;
      for (int i = elapsed + 1; i <= W + 4; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
         check("busy_run", {31'd0, bus.busy}, 32'd1);
      end
      check("latency", lat, W);
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_sign", {31'd0, bus.sign}, 32'd0);
      check("rst_mag", {25'd0, bus.mag}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         launch(vecs[i]);
         wait_done(0);
         @(negedge clk);
         check("done_drop", {31'd0, bus.done}, 32'd0);
      end

      // start with a different x mid-conversion must be ignored
      launch(7'b1110100);
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.x     = 7'b0000101;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_ignored_start", {31'd0, bus.busy}, 32'd1);
      wait_done(3);
      @(negedge clk);
      check("done_drop_ign", {31'd0, bus.done}, 32'd0);
      check("busy_after_ign", {31'd0, bus.busy}, 32'd0);

      // back-to-back: second start presented during the DONE cycle
      launch(7'b1110100);
      wait_done(0);
      launch(7'b1101011);
      wait_done(0);
      @(negedge clk);

      // asynchronous reset mid-conversion
      launch(7'b1110100);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      sb_q.delete();
      n_exp_done--;
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_done", {31'd0, bus.done}, 32'd0);
      check("midrst_sign", {31'd0, bus.sign}, 32'd0);
      check("midrst_mag", {25'd0, bus.mag}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) @(negedge clk);
      check("no_done_after_rst", n_done, n_exp_done);
      launch(7'b1110100);
      wait_done(0);
      @(negedge clk);

      check("sb_empty", sb_q.size(), 0);
      check("done_count", n_done, n_exp_done);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
